// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM.
// A CPU port (read/write) and a video port (read only) share one memory port.
// Every access takes a fixed four-state walk: IDLE -> ISSUE -> WAIT -> ACK.
// Video has priority. The CPU is starved for at most MAX_WAIT video grants.
//
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i    CPU request
//   cpu_ack_o/cpu_rdata_o                        CPU completion pulse, read data
//   vid_req_i/vid_addr_i                         video read request
//   vid_ack_o/vid_rdata_o                        video completion pulse, read data
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i  BRAM port (1-cycle read latency)
//   busy_o                                       high whenever not idle
module bram_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_ack_o,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic              owner_cpu_q, owner_cpu_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic              grant_cpu, grant_vid;

  always_comb begin
    state_d     = state_q;
    owner_cpu_d = owner_cpu_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    grant_cpu   = 1'b0;
    grant_vid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        grant_cpu = cpu_req_i && (!vid_req_i || (wait_cnt_q == MaxCnt));
        grant_vid = vid_req_i && !grant_cpu;
        if (grant_cpu) begin
          state_d     = StIssue;
          owner_cpu_d = 1'b1;
          addr_d      = cpu_addr_i;
          we_d        = cpu_we_i;
          wdata_d     = cpu_wdata_i;
          wait_cnt_d  = '0;
        end else if (grant_vid) begin
          // Video never writes; wdata_q is left alone so mem_wdata keeps its last value.
          state_d     = StIssue;
          owner_cpu_d = 1'b0;
          addr_d      = vid_addr_i;
          we_d        = 1'b0;
          if (cpu_req_i && (wait_cnt_q != MaxCnt)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // BRAM data for the address driven in ISSUE is valid during WAIT.
        state_d = StAck;
        if (!we_q) begin
          if (owner_cpu_q) cpu_rdata_d = mem_rdata_i;
          else             vid_rdata_d = mem_rdata_i;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_cpu_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_cpu_q <= owner_cpu_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  // addr_q/wdata_q only change on a grant, so they already hold their last value
  // outside ISSUE and can drive the BRAM port directly.
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = (state_q == StIssue) && we_q;
  assign cpu_ack_o   = (state_q == StAck) && owner_cpu_q;
  assign vid_ack_o   = (state_q == StAck) && !owner_cpu_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign vid_rdata_o = vid_rdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_bram_arbiter.sv
module tb_bram_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o  (cpu_ack),
    .cpu_rdata_o(cpu_rdata),
    .vid_req_i  (vid_req),
    .vid_addr_i (vid_addr),
    .vid_ack_o  (vid_ack),
    .vid_rdata_o(vid_rdata),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy)
  );

  // BRAM model: synchronous write, registered read (data valid one clock later).
  logic [DW-1:0] bram [0:1023];
  logic          bram_clr = 1'b1;
  always @(posedge clk) begin
    if (bram_clr) begin
      for (int i = 0; i < 1024; i++) bram[i] <= '0;
      bram[10'h200] <= 16'h1234;
    end else if (mem_we) begin
      bram[mem_addr[9:0]] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One access from IDLE. Reports ack cycle (-1 if none), mem_we pulse count and
  // the address/data seen while mem_we was high, and whether the other ack fired.
  task automatic run_access(input bit is_cpu, input bit we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input bit chg_addr,
                            output int ack_cyc, output int we_cnt,
                            output logic [AW-1:0] we_addr, output logic [DW-1:0] we_data,
                            output int other_ack);
    ack_cyc = -1; we_cnt = 0; we_addr = '0; we_data = '0; other_ack = 0;
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      vid_req = 1'b1; vid_addr = addr;
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1 && chg_addr) cpu_addr = 16'h0020;
      if (mem_we) begin
        we_cnt++; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (is_cpu ? vid_ack : cpu_ack) other_ack = 1;
      if (is_cpu ? cpu_ack : vid_ack) begin
        ack_cyc = c;
        break;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int            ack_cyc, we_cnt, other_ack;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  logic [7:0]    seq;
  int            got, last_cyc, both, leak;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    bram_clr = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_acks", 32'({cpu_ack, vid_ack, mem_we}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_rdata", 32'({cpu_rdata, vid_rdata}), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // CPU write 0xBEEF to 0x0010
    run_access(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("wr_ack_lat", 32'(ack_cyc), 32'd3);
    check_eq("wr_we_cnt", 32'(we_cnt), 32'd1);
    check_eq("wr_addr", 32'(we_addr), 32'h0010);
    check_eq("wr_data", 32'(we_data), 32'hBEEF);
    check_eq("wr_vid_ack", 32'(other_ack), 32'd0);
    check_eq("wr_rdata_kept", 32'(cpu_rdata), 32'd0);
    check_eq("wr_idle", 32'(busy), 32'd0);

    // CPU read back 0x0010
    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("rd_ack_lat", 32'(ack_cyc), 32'd3);
    check_eq("rd_we_cnt", 32'(we_cnt), 32'd0);
    check_eq("rd_data", 32'(cpu_rdata), 32'hBEEF);

    // Video read 0x0200 while CPU idle
    run_access(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("vid_ack_lat", 32'(ack_cyc), 32'd3);
    check_eq("vid_data", 32'(vid_rdata), 32'h1234);
    check_eq("vid_cpu_ack", 32'(other_ack), 32'd0);
    check_eq("vid_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    check_eq("vid_we_cnt", 32'(we_cnt), 32'd0);

    // CPU address changed during ISSUE must not affect the access in flight
    run_access(1'b1, 1'b1, 16'h0010, 16'hCAFE, 1'b1, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("chg_addr", 32'(we_addr), 32'h0010);
    check_eq("chg_data", 32'(we_data), 32'hCAFE);
    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("chg_rd10", 32'(cpu_rdata), 32'hCAFE);
    run_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("chg_rd20", 32'(cpu_rdata), 32'h0000);

    // Both requesting continuously: V,V,V,C,V,V,V,C
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    vid_req = 1'b1; vid_addr = 16'h0200;
    seq = '0; got = 0; last_cyc = -1; both = 0;
    for (int c = 1; c <= 48 && got < 8; c++) begin
      @(posedge clk); #1;
      if (cpu_ack && vid_ack) both = 1;
      if (cpu_ack || vid_ack) begin
        seq[got] = cpu_ack;
        got++;
        last_cyc = c;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    @(posedge clk); #1;
    check_eq("arb_grants", 32'(got), 32'd8);
    check_eq("arb_order", 32'(seq), 32'h88);
    check_eq("arb_both_ack", 32'(both), 32'd0);
    check_eq("arb_last_cyc", 32'(last_cyc), 32'd31);
    check_eq("arb_cpu_rdata", 32'(cpu_rdata), 32'hCAFE);
    check_eq("arb_vid_rdata", 32'(vid_rdata), 32'h1234);

    // Reset during WAIT of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    check_eq("mid_busy", 32'(busy), 32'd0);
    check_eq("mid_acks", 32'({cpu_ack, vid_ack, mem_we}), 32'd0);
    check_eq("mid_mem", 32'({mem_addr, mem_wdata}), 32'd0);
    check_eq("mid_rdata", 32'({cpu_rdata, vid_rdata}), 32'd0);
    leak = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (cpu_ack || vid_ack || mem_we || busy) leak = 1;
    end
    check_eq("mid_no_ack", 32'(leak), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_access(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, ack_cyc, we_cnt, we_addr, we_data, other_ack);
    check_eq("post_rst_lat", 32'(ack_cyc), 32'd3);
    check_eq("post_rst_data", 32'(cpu_rdata), 32'hCAFE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: address width.
REQ-002 SHALL have parameter DATA_W, default 16: data width.
REQ-003 SHALL have parameter MAX_WAIT, default 3: maximum consecutive video grants while the CPU waits.
REQ-004 SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-007 SHALL have port cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-008 SHALL have ports cpu_addr  input  ADDR_W  and  cpu_wdata  input  DATA_W  CPU address and write data.
REQ-009 SHALL have port cpu_ack  output  1  one-cycle completion pulse for a CPU access.
REQ-010 SHALL have port cpu_rdata  output  DATA_W  CPU read data.
REQ-011 SHALL have port vid_req  input  1  video read request (read only).
REQ-012 SHALL have port vid_addr  input  ADDR_W  video read address.
REQ-013 SHALL have port vid_ack  output  1  one-cycle completion pulse for a video read.
REQ-014 SHALL have port vid_rdata  output  DATA_W  video read data.
REQ-015 SHALL have ports mem_addr  output  ADDR_W,  mem_we  output  1,  mem_wdata  output  DATA_W  BRAM port drive.
REQ-016 SHALL have port mem_rdata  input  DATA_W  BRAM read data, valid one clock after the address is presented.
REQ-017 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL implement four states: IDLE, ISSUE, WAIT, ACK; transitions ISSUE->WAIT->ACK->IDLE are unconditional.
REQ-019 In IDLE, SHALL sample cpu_req and vid_req: neither -> stay IDLE; exactly one -> grant it; both -> grant video unless wait_cnt == MAX_WAIT, then grant CPU.
REQ-020 On grant, SHALL latch owner, address, we (0 for video) and wdata, then enter ISSUE; requester inputs are ignored until the next IDLE.
REQ-021 wait_cnt SHALL increment on each video grant made while cpu_req is high, saturate at MAX_WAIT, and clear on every CPU grant.
REQ-022 In ISSUE, SHALL drive mem_addr and mem_wdata from the latched values; mem_we = latched we.
REQ-023 mem_we SHALL be 0 in every state other than ISSUE; mem_addr and mem_wdata SHALL hold their last value.
REQ-024 On the edge leaving WAIT, SHALL load the owner's rdata register from mem_rdata, for reads only; writes leave cpu_rdata unchanged.
REQ-025 The owner's ack SHALL be high for exactly the ACK cycle; the other ack stays 0; cpu_ack and vid_ack are never high together.
REQ-026 cpu_rdata and vid_rdata SHALL hold their value until the next read completion for the same owner.
REQ-027 Latency SHALL be fixed: request seen in IDLE at cycle t -> ack at cycle t+3; maximum throughput is one access per 4 cycles.
REQ-028 A requester SHALL deassert req during its ack cycle; a req still high in the following IDLE is treated as a new request.
REQ-029 CPU worst-case wait under continuous video load SHALL be MAX_WAIT video accesses.

Reset
REQ-030 While reset is low, SHALL force: state IDLE; cpu_ack, vid_ack, mem_we, busy = 0; wait_cnt, owner, latched registers, mem_addr, mem_wdata, cpu_rdata, vid_rdata = 0.
REQ-031 Reset asserted mid-access SHALL abandon the access with no ack and no further mem_we pulse.

Verification
REQ-032 CPU write only: cpu_req=1, we=1, addr=0x0010, wdata=0xBEEF -> mem_we=1 with addr 0x0010, data 0xBEEF, for exactly one cycle; cpu_ack 3 cycles after the IDLE sample.
REQ-033 CPU read only: BRAM[0x0010]=0xBEEF, cpu_req=1, we=0 -> cpu_ack at t+3 with cpu_rdata=0xBEEF; mem_we never high.
REQ-034 Simultaneous requests, MAX_WAIT=3, both req held continuously: grant order V,V,V,C,V,V,V,C; wait_cnt returns to 0 after each C.
REQ-035 Video read of 0x0200 (data 0x1234) while CPU idle -> vid_ack at t+3, vid_rdata=0x1234; cpu_ack=0; cpu_rdata unchanged.
REQ-036 Reset pulsed during WAIT of a CPU read -> no cpu_ack; all outputs 0; next cpu_req is served from IDLE with the normal latency.
REQ-037 Address change after grant: cpu_addr changed 0x0010->0x0020 during ISSUE -> mem_addr stays 0x0010 for that access.
